fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequencer for the instruction-fetch stage (PC/NPC + IROM) of the pipelined core.
//  Decides each cycle whether the PC advances, takes a redirect target, or holds.
//  Writes or flushes the IF/ID and ID/EX registers, and counts IROM wait states.
//  Sits between the hazard unit / EX branch resolution and the fetch datapath.
// PARAMETERS
//  IROM_LAT  1  IROM wait cycles per fetch (0 = single-cycle IROM); legal 0..7
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  rst          in   1  synchronous reset, active-low
//  ex_redirect  in   1  EX resolved a taken branch/jump this cycle
//  id_hazard    in   1  load-use hazard: ID must hold one cycle
//  ext_halt     in   1  debug halt request, level-sensitive
//  pc_we        out  1  PC register write enable
//  npc_take     out  1  NPC selects the EX redirect target, not pc+4
//  if_id_we     out  1  IF/ID register write enable
//  if_id_flush  out  1  load a bubble into IF/ID
//  id_ex_flush  out  1  load a bubble into ID/EX
//  fetch_valid  out  1  IROM word presented this cycle is a valid instruction
//  fsm_state    out  2  current state: 0 BOOT, 1 FETCH, 2 HALT
// BEHAVIOUR
//  - States: BOOT, FETCH, HALT; wait counter wcnt, width max(1,$clog2(IROM_LAT+1)).
//  - rst==0 at an edge: state<=BOOT and wcnt<=IROM_LAT.
//  - While rst==0, every output is forced to 0, fsm_state included.
//  - Reset mid-fetch silently drops any in-flight fetch.
//  - All outputs are combinational functions of the state, wcnt and inputs.
//  - BOOT: lasts 1 cycle. All enables are 0, if_id_flush=1, id_ex_flush=1. Next: FETCH, wcnt=IROM_LAT.
//  - FETCH, wcnt!=0 (IROM busy): pc_we=0 and fetch_valid=0. wcnt decrements.
//      * id_hazard=0: if_id_flush=1, so a bubble enters ID.
//      * id_hazard=1: if_id_we=0 and if_id_flush=0 (ID holds), id_ex_flush=1.
//  - FETCH, wcnt==0 (word ready). Priority is redirect > hazard > halt > normal:
//      * ex_redirect: pc_we=1, npc_take=1, if_id_flush=1, id_ex_flush=1, wcnt<=IROM_LAT.
//      * id_hazard: pc_we=0, if_id_we=0, id_ex_flush=1. Stay with wcnt=0, so the word is re-presented.
//      * ext_halt: all enables 0. Next state HALT. The PC holds the un-issued instruction.
//      * normal: pc_we=1, if_id_we=1, fetch_valid=1, wcnt<=IROM_LAT.
//  - ex_redirect while wcnt!=0 aborts the fetch, with the same outputs as the redirect case above.
//    The redirect is never dropped or deferred.
//  - Redirect and halt in the same cycle: the redirect completes, and HALT is entered on a later word-ready cycle.
//  - HALT: pc_we=if_id_we=fetch_valid=0, if_id_flush=0, id_ex_flush=1.
//      * ex_redirect and id_hazard are ignored.
//      * When ext_halt drops, go to FETCH with wcnt=IROM_LAT.
//  - IROM_LAT=0: wcnt is permanently 0 and a normal fetch retires every cycle.
//  - npc_take=1 only when pc_we=1. if_id_we and if_id_flush are never both 1.
// CONFIGURATION
//  FETCH_CTRL_PERF_EN defined adds two ports:
//    stall_cnt out 32: counts cycles with pc_we=0 in FETCH.
//    flush_cnt out 32: counts redirect cycles.
//    Both saturate at 32'hFFFF_FFFF and clear on reset.
//  FETCH_CTRL_PERF_EN undefined: neither port exists and no counter logic is built.
// TESTING
//  IROM_LAT=2, reset released -> BOOT for 1 cycle, then pc_we pulses every 3rd cycle with fetch_valid=1.
//  IROM_LAT=0, no hazards, 10 cycles after BOOT -> pc_we=if_id_we=fetch_valid=1 on all 10 cycles.
//  IROM_LAT=0, id_hazard=1 for 1 cycle -> pc_we=0, if_id_we=0, id_ex_flush=1; next cycle resumes.
//  IROM_LAT=2, ex_redirect at wcnt=1 -> pc_we=npc_take=1, both flushes=1; the next pulse comes 3 cycles later.
//  ext_halt=1 at a word-ready cycle -> HALT (fsm_state=2) for 5 cycles; release -> FETCH after IROM_LAT+1 cycles.
//  rst=0 for 1 cycle mid-wait (wcnt=1) -> all outputs 0, then BOOT; perf counters (if built) read 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC advance/redirect/hold, IF/ID and ID/EX write/flush, IROM wait counting.
// Optional build macro FETCH_CTRL_PERF_EN adds saturating stall_cnt/flush_cnt performance counters.
module fetch_ctrl #(
    parameter int unsigned IROM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_redirect,
    input  logic        id_hazard,
    input  logic        ext_halt,
    output logic        pc_we,
    output logic        npc_take,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        fetch_valid,
    output logic [1:0]  fsm_state
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int unsigned WW = (IROM_LAT > 0) ? $clog2(IROM_LAT + 1) : 1;
    localparam logic [WW-1:0] LAT_W = WW'(IROM_LAT);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic            word_ready_s;
    logic            redirect_s;
    logic            pc_we_s, npc_take_s, if_id_we_s, if_id_flush_s, id_ex_flush_s, fetch_valid_s;

    assign word_ready_s = (wcnt_q == {WW{1'b0}});

    // State and wait-counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_BOOT;
            wcnt_q  <= LAT_W;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state and raw control decode; a redirect always wins, even over a busy IROM.
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        redirect_s    = 1'b0;
        pc_we_s       = 1'b0;
        npc_take_s    = 1'b0;
        if_id_we_s    = 1'b0;
        if_id_flush_s = 1'b0;
        id_ex_flush_s = 1'b0;
        fetch_valid_s = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if_id_flush_s = 1'b1;
                id_ex_flush_s = 1'b1;
                state_d       = ST_FETCH;
                wcnt_d        = LAT_W;
            end
            ST_FETCH: begin
                if (ex_redirect) begin
                    redirect_s    = 1'b1;
                    pc_we_s       = 1'b1;
                    npc_take_s    = 1'b1;
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                    wcnt_d        = LAT_W;
                end else if (!word_ready_s) begin
                    wcnt_d = wcnt_q - WW'(1'b1);
                    if (id_hazard) begin
                        id_ex_flush_s = 1'b1;
                    end else begin
                        if_id_flush_s = 1'b1;
                    end
                end else if (id_hazard) begin
                    // Hold with wcnt at zero so the same word is presented again.
                    id_ex_flush_s = 1'b1;
                end else if (ext_halt) begin
                    state_d = ST_HALT;
                end else begin
                    pc_we_s       = 1'b1;
                    if_id_we_s    = 1'b1;
                    fetch_valid_s = 1'b1;
                    wcnt_d        = LAT_W;
                end
            end
            ST_HALT: begin
                id_ex_flush_s = 1'b1;
                if (!ext_halt) begin
                    state_d = ST_FETCH;
                    wcnt_d  = LAT_W;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_BOOT;
                wcnt_d  = LAT_W;
            end
        endcase
    end

    // Output gating: everything reads zero while reset is asserted.
    always_comb begin
        if (!rst) begin
            pc_we       = 1'b0;
            npc_take    = 1'b0;
            if_id_we    = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            fetch_valid = 1'b0;
            fsm_state   = 2'b00;
        end else begin
            pc_we       = pc_we_s;
            npc_take    = npc_take_s;
            if_id_we    = if_id_we_s;
            if_id_flush = if_id_flush_s;
            id_ex_flush = id_ex_flush_s;
            fetch_valid = fetch_valid_s;
            fsm_state   = state_q;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating counter next-state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q == ST_FETCH) && !pc_we_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (redirect_s && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Performance counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: an IROM_LAT=2 and an IROM_LAT=0 instance share stimulus
// and are compared every cycle against a behavioural model; directed scenarios then random traffic.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, red, haz, hlt;
    wire [5:0] f2, f0;
    wire [1:0] s2, s0;
`ifdef FETCH_CTRL_PERF_EN
    wire [31:0] sc2, fc2, sc0, fc0;
`endif

    fetch_ctrl #(.IROM_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .ex_redirect(red), .id_hazard(haz), .ext_halt(hlt),
        .pc_we(f2[5]), .npc_take(f2[4]), .if_id_we(f2[3]), .if_id_flush(f2[2]),
        .id_ex_flush(f2[1]), .fetch_valid(f2[0]), .fsm_state(s2)
`ifdef FETCH_CTRL_PERF_EN
        , .stall_cnt(sc2), .flush_cnt(fc2)
`endif
    );

    fetch_ctrl #(.IROM_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .ex_redirect(red), .id_hazard(haz), .ext_halt(hlt),
        .pc_we(f0[5]), .npc_take(f0[4]), .if_id_we(f0[3]), .if_id_flush(f0[2]),
        .id_ex_flush(f0[1]), .fetch_valid(f0[0]), .fsm_state(s0)
`ifdef FETCH_CTRL_PERF_EN
        , .stall_cnt(sc0), .flush_cnt(fc0)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Model: mode 0 boot, 1 fetching, 2 halted; wt = IROM cycles still to wait for the current word.
    int lat    [2] = '{2, 0};
    int m_mode [2];
    int m_wait [2];
    longint m_stall [2];
    longint m_flush [2];

    // Expected {pc_we, npc_take, if_id_we, if_id_flush, id_ex_flush, fetch_valid, fsm_state}.
    function automatic logic [7:0] exp_out(int mode, int wt, logic r, logic rd, logic hz, logic ht);
        if (!r)             return 8'b000000_00;
        if (mode == 0)      return 8'b000110_00;
        if (mode == 2)      return 8'b000010_10;
        if (rd)             return 8'b110110_01;
        if (wt > 0)         return hz ? 8'b000010_01 : 8'b000100_01;
        if (hz)             return 8'b000010_01;
        if (ht)             return 8'b000000_01;
        return 8'b101001_01;
    endfunction

    task automatic cycle(input logic r, input logic rd, input logic hz, input logic ht, input string tag);
        logic [7:0] exp, obs;
        @(negedge clk);
        rst = r; red = rd; haz = hz; hlt = ht;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp = exp_out(m_mode[k], m_wait[k], r, rd, hz, ht);
            obs = (k == 0) ? {f2, s2} : {f0, s0};
            checks++;
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s lat%0d: observed=%b expected=%b", tag, lat[k], obs, exp);
            end
            if (!r) begin
                m_mode[k] = 0; m_wait[k] = lat[k]; m_stall[k] = 0; m_flush[k] = 0;
            end else if (m_mode[k] == 0) begin
                m_mode[k] = 1; m_wait[k] = lat[k];
            end else if (m_mode[k] == 2) begin
                if (!ht) begin m_mode[k] = 1; m_wait[k] = lat[k]; end
            end else begin
                if (!exp[7]) m_stall[k]++;
                if (rd) begin
                    m_flush[k]++; m_wait[k] = lat[k];
                end else if (m_wait[k] > 0) begin
                    m_wait[k]--;
                end else if (hz) begin
                    m_wait[k] = 0;
                end else if (ht) begin
                    m_mode[k] = 2;
                end else begin
                    m_wait[k] = lat[k];
                end
            end
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef FETCH_CTRL_PERF_EN
        @(negedge clk);
        #1;
        checks++;
        assert ({sc2, fc2} === {m_stall[0][31:0], m_flush[0][31:0]}) else begin
            errors++;
            $error("FAIL %s lat2: observed=%0d/%0d expected=%0d/%0d", tag, sc2, fc2, m_stall[0], m_flush[0]);
        end
        checks++;
        assert ({sc0, fc0} === {m_stall[1][31:0], m_flush[1][31:0]}) else begin
            errors++;
            $error("FAIL %s lat0: observed=%0d/%0d expected=%0d/%0d", tag, sc0, fc0, m_stall[1], m_flush[1]);
        end
`endif
    endtask

    logic ht_lvl;

    initial begin
        rst = 1'b0; red = 1'b0; haz = 1'b0; hlt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_wait[k] = lat[k]; m_stall[k] = 0; m_flush[k] = 0;
        end

        cycle(1'b0, 1'b0, 1'b0, 1'b0, "reset");
        cycle(1'b0, 1'b1, 1'b1, 1'b1, "reset_forced");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, "boot");
        for (int n = 0; n < 10; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, "stream");

        cycle(1'b1, 1'b0, 1'b1, 1'b0, "hazard");
        for (int n = 0; n < 3; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, "post_hazard");

        for (int n = 0; n < 4 && m_wait[0] != 1; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, "align");
        cycle(1'b1, 1'b1, 1'b0, 1'b0, "redirect_wait");
        for (int n = 0; n < 4; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, "post_redirect");

        for (int n = 0; n < 4 && m_wait[0] != 0; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, "align");
        cycle(1'b1, 1'b0, 1'b0, 1'b1, "halt_enter");
        for (int n = 0; n < 5; n++) cycle(1'b1, n[0], n[1], 1'b1, "halt_hold");
        for (int n = 0; n < 4; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, "halt_release");

        cycle(1'b1, 1'b1, 1'b0, 1'b1, "redirect_halt");
        for (int n = 0; n < 4; n++) cycle(1'b1, 1'b0, 1'b0, 1'b1, "halt_after_redirect");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, "release2");
        check_perf("perf_mid");

        for (int n = 0; n < 4 && m_wait[0] != 1; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, "align");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, "reset_mid_wait");
        check_perf("perf_after_reset");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, "boot2");
        for (int n = 0; n < 3; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, "restart");

        ht_lvl = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) ht_lvl = ~ht_lvl;
            cycle($urandom_range(0, 59) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 4) == 0, ht_lvl, "random");
        end
        check_perf("perf_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
